// File: rtl/pll_mode_reconfig.sv
// Sequences NTSC/PAL reconfiguration of the system PLL over the reconfig IP's
// Avalon-MM management port, and holds the core in reset until lock is stable.
`timescale 1ns/1ps

module pll_mode_reconfig #(
   parameter logic [31:0] NTSC_M       = 32'h0000_0808,
   parameter logic [31:0] NTSC_K       = 32'h4D6A_1F3C,
   parameter logic [31:0] PAL_M        = 32'h0000_0808,
   parameter logic [31:0] PAL_K        = 32'h2F1B_8A41,
   parameter int          LOCK_STABLE  = 1024,
   parameter int          LOCK_TIMEOUT = 1000000,
   parameter int          MAX_RETRY    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pal_mode,
   input  logic        pll_locked,
   output logic        pll_rst,
   output logic [5:0]  mgmt_address,
   output logic        mgmt_write,
   output logic [31:0] mgmt_writedata,
   input  logic        mgmt_waitrequest,
   output logic        core_reset,
   output logic        cur_pal,
   output logic        busy,
   output logic        error
);

   localparam int LCW = $clog2(LOCK_STABLE + 1);
   localparam int TW  = $clog2(LOCK_TIMEOUT + 1);
   localparam int RW  = $clog2(MAX_RETRY + 1);

   localparam logic [LCW-1:0] STABLE_VAL   = LCW'(LOCK_STABLE);
   localparam logic [TW-1:0]  IGNORE_LAST  = TW'(64);
   localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [RW-1:0]  RETRY_LIMIT  = RW'(MAX_RETRY);
   localparam logic [3:0]     RST_LAST     = 4'd15;

   typedef enum logic [3:0] {
      PLL_RST, WAIT_INIT, RUN, WR_MODE, WR_M, WR_K, WR_START, WAIT_LOCK, HALT
   } state_t;

   state_t          state, state_n, wr_next;
   logic [3:0]      rst_cnt;
   logic            lock_meta, lock_sync;
   logic [LCW-1:0]  lock_cnt;
   logic            stable;
   logic [TW-1:0]   timer;
   logic [RW-1:0]   retry_cnt, retry_n;
   logic            target, target_n;
   logic            mism_q;
   logic            cur_pal_n, error_n;
   logic            write_n;
   logic [5:0]      addr_n, wr_addr;
   logic [31:0]     data_n, wr_data;
   logic            accept;

   assign stable     = (lock_cnt == STABLE_VAL);
   assign accept     = mgmt_write && !mgmt_waitrequest;
   assign pll_rst    = (state == PLL_RST);
   assign core_reset = (state != RUN);
   assign busy       = (state != RUN);

   // NOTE: every sequential block uses <= so all registers update together
   // from the values seen before the edge, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
         lock_cnt  <= '0;
      end else begin
         lock_meta <= pll_locked;
         lock_sync <= lock_meta;
         if (!lock_sync)
            lock_cnt <= '0;
         else if (lock_cnt != STABLE_VAL)
            lock_cnt <= lock_cnt + LCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= PLL_RST;
         rst_cnt        <= '0;
         timer          <= '0;
         retry_cnt      <= '0;
         target         <= 1'b0;
         mism_q         <= 1'b0;
         cur_pal        <= 1'b0;
         error          <= 1'b0;
         mgmt_write     <= 1'b0;
         mgmt_address   <= '0;
         mgmt_writedata <= '0;
      end else begin
         state          <= state_n;
         rst_cnt        <= (state == PLL_RST) ? rst_cnt + 4'd1 : 4'd0;
         retry_cnt      <= retry_n;
         target         <= target_n;
         mism_q         <= (state == RUN) && (pal_mode != cur_pal);
         cur_pal        <= cur_pal_n;
         error          <= error_n;
         mgmt_write     <= write_n;
         mgmt_address   <= addr_n;
         mgmt_writedata <= data_n;
         if (state == WR_START && accept)
            timer <= '0;
         else if (state == WAIT_LOCK && timer != TIMEOUT_LAST)
            timer <= timer + TW'(1);
      end
   end

   // Register image for the write the current state is responsible for.
   always_comb begin
      wr_addr = '0;
      wr_data = '0;
      wr_next = WAIT_LOCK;
      case (state)
         WR_MODE:  begin wr_addr = 6'h00; wr_data = 32'd1;                 wr_next = WR_M;     end
         WR_M:     begin wr_addr = 6'h04; wr_data = target ? PAL_M : NTSC_M; wr_next = WR_K;     end
         WR_K:     begin wr_addr = 6'h07; wr_data = target ? PAL_K : NTSC_K; wr_next = WR_START; end
         WR_START: begin wr_addr = 6'h02; wr_data = 32'd1;                 wr_next = WAIT_LOCK; end
         default:  ;
      endcase
   end

   // NOTE: every output of this block gets a hold default first, so no path
   // through the case can leave a value unassigned and infer a latch.
   always_comb begin
      state_n   = state;
      target_n  = target;
      cur_pal_n = cur_pal;
      error_n   = error;
      retry_n   = retry_cnt;
      write_n   = mgmt_write;
      addr_n    = mgmt_address;
      data_n    = mgmt_writedata;
      case (state)
         PLL_RST:
            if (rst_cnt == RST_LAST) state_n = WAIT_INIT;
         WAIT_INIT:
            if (stable) begin
               // A pending retry replays the latched target, not pal_mode.
               if (retry_cnt != '0) begin
                  state_n = WR_MODE;
               end else begin
                  target_n = pal_mode;
                  state_n  = (pal_mode != cur_pal) ? WR_MODE : RUN;
               end
            end
         RUN:
            if (!lock_sync) begin
               state_n = WAIT_INIT;
            end else if (mism_q && (pal_mode != cur_pal)) begin
               target_n = pal_mode;
               state_n  = WR_MODE;
            end
         WR_MODE, WR_M, WR_K, WR_START:
            if (accept) begin
               write_n = 1'b0;
               state_n = wr_next;
            end else begin
               write_n = 1'b1;
               addr_n  = wr_addr;
               data_n  = wr_data;
            end
         WAIT_LOCK:
            if (timer >= IGNORE_LAST && stable) begin
               cur_pal_n = target;
               retry_n   = '0;
               state_n   = WAIT_INIT;
            end else if (timer == TIMEOUT_LAST) begin
               retry_n = retry_cnt + RW'(1);
               if (retry_cnt + RW'(1) < RETRY_LIMIT) begin
                  state_n = PLL_RST;
               end else begin
                  error_n = 1'b1;
                  state_n = HALT;
               end
            end
         HALT: ;
         default:
            state_n = PLL_RST;
      endcase
   end

endmodule

// File: tb/tb_pll_mode_reconfig.sv
// Directed bench for pll_mode_reconfig: a small PLL / reconfig-IP model drives
// lock and waitrequest, and the main sequence checks timing and write order.
`timescale 1ns/1ps

module tb_pll_mode_reconfig;

   localparam logic [31:0] NTSC_M = 32'h0000_0808;
   localparam logic [31:0] NTSC_K = 32'h4D6A_1F3C;
   localparam logic [31:0] PAL_M  = 32'h0000_0808;
   localparam logic [31:0] PAL_K  = 32'h2F1B_8A41;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pal_mode = 1'b0;
   logic        pll_locked = 1'b0;
   logic        mgmt_waitrequest = 1'b0;
   logic        pll_rst, mgmt_write, core_reset, cur_pal, busy, error;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;

   initial forever #5 clk = ~clk;

   pll_mode_reconfig #(.LOCK_TIMEOUT(2000)) dut (
      .clk(clk), .rst(rst), .pal_mode(pal_mode), .pll_locked(pll_locked),
      .pll_rst(pll_rst), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
      .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
      .core_reset(core_reset), .cur_pal(cur_pal), .busy(busy), .error(error)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Model state (written only by the model process, except the request flags).
   logic [5:0]  acc_addr[$];
   logic [31:0] acc_data[$];
   int          rst_runs[$];
   int          hold_viol = 0, drop_viol = 0, m_cycles = 0;
   int          relock_cnt = 0, stall_left = 0, run_len = 0;
   int          glitch_req = 0, glitch_ack = 0;
   bit          glitch_restore = 0, pending = 0, last_acc = 0;
   bit          fail_relock = 0, stall_en = 0;
   logic [5:0]  p_addr = '0;
   logic [31:0] p_data = '0;

   // PLL and reconfig-IP model; evaluates what the next rising edge will see.
   initial begin
      forever begin
         @(negedge clk);
         if (glitch_restore) begin
            pll_locked = 1'b1;
            glitch_restore = 0;
         end else if (glitch_req != glitch_ack) begin
            pll_locked = 1'b0;
            glitch_ack = glitch_req;
            glitch_restore = 1;
         end else if (pll_rst === 1'b1) begin
            pll_locked = 1'b0;
            relock_cnt = 100;
         end else if (relock_cnt > 0) begin
            relock_cnt--;
            if (relock_cnt == 0) pll_locked = 1'b1;
         end

         if (pll_rst === 1'b1) run_len++;
         else if (run_len > 0) begin
            rst_runs.push_back(run_len);
            run_len = 0;
         end

         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) mgmt_waitrequest = 1'b0;
         end else if (stall_en && mgmt_write === 1'b1 && mgmt_address == 6'h04) begin
            mgmt_waitrequest = 1'b1;
            stall_left = 7;
         end

         if (pending && (mgmt_write !== 1'b1 || mgmt_address !== p_addr || mgmt_writedata !== p_data))
            hold_viol++;
         if (last_acc && mgmt_write !== 1'b0) drop_viol++;
         if (mgmt_write === 1'b1 && mgmt_address == 6'h04) m_cycles++;
         last_acc = (mgmt_write === 1'b1) && !mgmt_waitrequest;
         pending  = (mgmt_write === 1'b1) && mgmt_waitrequest;
         p_addr   = mgmt_address;
         p_data   = mgmt_writedata;
         if (last_acc) begin
            acc_addr.push_back(mgmt_address);
            acc_data.push_back(mgmt_writedata);
            if (mgmt_address == 6'h02) begin
               pll_locked = 1'b0;
               relock_cnt = fail_relock ? 0 : 200;
            end
         end
      end
   end

   task automatic check_seq(input string tag, input int idx, input logic [31:0] m, input logic [31:0] k);
      check({tag, "_mode_addr"},  32'(acc_addr[idx]),   32'h00);
      check({tag, "_mode_data"},  acc_data[idx],        32'd1);
      check({tag, "_m_addr"},     32'(acc_addr[idx+1]), 32'h04);
      check({tag, "_m_data"},     acc_data[idx+1],      m);
      check({tag, "_k_addr"},     32'(acc_addr[idx+2]), 32'h07);
      check({tag, "_k_data"},     acc_data[idx+2],      k);
      check({tag, "_start_addr"}, 32'(acc_addr[idx+3]), 32'h02);
      check({tag, "_start_data"}, acc_data[idx+3],      32'd1);
   endtask

   task automatic wait_run(input int budget);
      int n = 0;
      while (core_reset !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n, first_hi, base, m0, hv0, dv0, r0, starts;

      // Power-up NTSC: reset values, pll_rst width, lock-to-release latency.
      repeat (4) @(negedge clk);
      check("rst_pll_rst", pll_rst, 1);
      check("rst_core_reset", core_reset, 1);
      check("rst_busy", busy, 1);
      check("rst_write", mgmt_write, 0);
      check("rst_addr", 32'(mgmt_address), 0);
      check("rst_data", mgmt_writedata, 0);
      check("rst_cur_pal", cur_pal, 0);
      check("rst_error", error, 0);
      rst = 1'b0;
      n = 0;
      do begin
         @(posedge clk); n++;
         @(negedge clk);
      end while (pll_rst === 1'b1 && n < 100);
      check("ntsc_pll_rst_len", n, 16);
      n = 0;
      do begin
         @(posedge clk); n++;
      end while (pll_locked !== 1'b1 && n < 500);
      check("ntsc_lock_seen", pll_locked, 1);
      n = 0;
      @(negedge clk);
      while (core_reset !== 1'b0 && n < 3000) begin
         @(posedge clk); n++;
         @(negedge clk);
      end
      check("ntsc_release_latency", n, 1026);
      check("ntsc_busy", busy, 0);
      check("ntsc_cur_pal", cur_pal, 0);
      check("ntsc_no_writes", acc_addr.size(), 0);

      // One-cycle lock glitch in RUN.
      repeat (20) @(negedge clk);
      base = acc_addr.size();
      @(posedge clk); glitch_req++;
      @(posedge clk);
      @(posedge clk);
      n = 0;
      first_hi = 0;
      while (n < 3000) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (core_reset === 1'b1 && first_hi == 0) first_hi = n;
         if (first_hi != 0 && core_reset === 1'b0) break;
      end
      check("glitch_reset_rise", first_hi, 1);
      check("glitch_release", n, 1026);
      check("glitch_no_writes", acc_addr.size() - base, 0);

      // Power-up PAL with a 7-cycle waitrequest stall on the M write.
      @(negedge clk);
      rst = 1'b1; pal_mode = 1'b1; stall_en = 1;
      base = acc_addr.size(); m0 = m_cycles; hv0 = hold_viol; dv0 = drop_viol;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      wait_run(6000);
      check("pal_reached_run", core_reset, 0);
      check("pal_accepts", acc_addr.size() - base, 4);
      check_seq("pal", base, PAL_M, PAL_K);
      check("pal_cur_pal", cur_pal, 1);
      check("pal_busy", busy, 0);
      check("stall_m_cycles", m_cycles - m0, 8);
      check("stall_hold_viol", hold_viol - hv0, 0);
      check("drop_viol", drop_viol - dv0, 0);
      stall_en = 0;

      // Runtime PAL->NTSC switch with pal_mode flipped back during WR_K.
      repeat (10) @(negedge clk);
      base = acc_addr.size();
      pal_mode = 1'b0;
      n = 0;
      while (!(mgmt_write === 1'b1 && mgmt_address == 6'h07) && n < 200) begin
         @(negedge clk); n++;
      end
      check("sw_reached_wr_k", 32'(mgmt_address), 32'h07);
      pal_mode = 1'b1;
      n = 0;
      while (acc_addr.size() < base + 5 && n < 5000) begin
         @(negedge clk); n++;
      end
      check("sw_cur_pal_mid", cur_pal, 0);
      check("sw_core_reset_mid", core_reset, 1);
      wait_run(6000);
      check("sw_accepts", acc_addr.size() - base, 8);
      check_seq("sw_ntsc", base, NTSC_M, NTSC_K);
      check_seq("sw_pal", base + 4, PAL_M, PAL_K);
      check("sw_cur_pal_end", cur_pal, 1);
      check("sw_drop_viol", drop_viol - dv0, 0);

      // Lock never returns after reconfiguration: three attempts, then HALT.
      @(negedge clk);
      rst = 1'b1; pal_mode = 1'b1; fail_relock = 1;
      base = acc_addr.size(); r0 = rst_runs.size();
      repeat (4) @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (error !== 1'b1 && n < 20000) begin
         @(negedge clk); n++;
      end
      check("fail_error", error, 1);
      repeat (50) @(negedge clk);
      starts = 0;
      for (int i = base; i < acc_addr.size(); i++)
         if (acc_addr[i] == 6'h02) starts++;
      check("fail_attempts", starts, 3);
      check("fail_accepts", acc_addr.size() - base, 12);
      check("fail_rst_runs", rst_runs.size() - r0, 3);
      check("fail_retry1_rst_len", rst_runs[rst_runs.size() - 2], 16);
      check("fail_retry2_rst_len", rst_runs[rst_runs.size() - 1], 16);
      check("halt_error_sticky", error, 1);
      check("halt_core_reset", core_reset, 1);
      check("halt_busy", busy, 1);
      rst = 1'b1; fail_relock = 0;
      @(negedge clk);
      check("rst_clears_error", error, 0);
      check("rst_cur_pal_ntsc", cur_pal, 0);
      check("rst_pll_rst_again", pll_rst, 1);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
